// File: rtl/octree_updater_if.sv
// Request/completion handshake and node-SRAM port between the octree controller
// (master) and the occupancy updater (slave).
interface octree_updater_if #(
    parameter int LVL_W  = 2,
    parameter int IDX_W  = 9,
    parameter int ADDR_W = 12
);
    logic              add_anchor;
    logic              del_anchor;
    logic [LVL_W-1:0]  anchor_level;
    logic [IDX_W-1:0]  anchor_idx;
    logic              add_done;
    logic              del_done;
    logic              err;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output add_anchor, del_anchor, anchor_level, anchor_idx, mem_rdata,
        input  add_done, del_done, err, busy, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  add_anchor, del_anchor, anchor_level, anchor_idx, mem_rdata,
        output add_done, del_done, err, busy, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/octree_updater.sv
// Octree occupancy updater: read-modify-write walk from an anchor's parent toward the root.
// Define OCTREE_DEL_PRUNE_EN to let deletes clear ancestors whose masks become empty.
module octree_updater #(
    parameter int TREE_DEPTH = 4,
    parameter int LVL_W      = 2,
    parameter int IDX_W      = 9,
    parameter int ADDR_W     = 12
) (
    input  logic clk,
    input  logic rst,
    octree_updater_if.slave bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_WR    = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

`ifdef OCTREE_DEL_PRUNE_EN
    localparam bit PRUNE = 1'b1;
`else
    localparam bit PRUNE = 1'b0;
`endif

    logic [2:0]        state_q, state_d;
    logic              op_del_q, op_del_d;
    logic              err_q, err_d;
    logic [LVL_W-1:0]  cl_q, cl_d;
    logic [IDX_W-1:0]  ci_q, ci_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              cont_q, cont_d;

    // Per-level node base addresses: base(l) = (8^l - 1) / 7.
    logic [ADDR_W-1:0] base_tab [TREE_DEPTH];
    for (genvar gi = 0; gi < TREE_DEPTH; gi++) begin : g_base
        localparam int BASE = ((1 << (3 * gi)) - 1) / 7;
        assign base_tab[gi] = ADDR_W'(BASE);
    end

    logic [LVL_W-1:0]  plvl;
    logic [ADDR_W-1:0] paddr;
    logic [7:0]        slot_bit;
    logic [7:0]        mask_set;
    logic [7:0]        mask_clr;
    logic              req_any;
    logic              lvl_valid;
    logic [IDX_W-1:0]  idx_masked;

    assign plvl       = cl_q - LVL_W'(1);
    assign paddr      = base_tab[plvl] + ADDR_W'(ci_q >> 3);
    assign slot_bit   = 8'b1 << ci_q[2:0];
    assign mask_set   = bus.mem_rdata | slot_bit;
    assign mask_clr   = bus.mem_rdata & ~slot_bit;
    assign req_any    = bus.add_anchor | bus.del_anchor;
    assign lvl_valid  = (bus.anchor_level != '0) && (int'(bus.anchor_level) < TREE_DEPTH);
    assign idx_masked = bus.anchor_idx & ~({IDX_W{1'b1}} << (3 * int'(bus.anchor_level)));

    always_comb begin
        state_d  = state_q;
        op_del_d = op_del_q;
        err_d    = err_q;
        cl_d     = cl_q;
        ci_d     = ci_q;
        wdata_d  = wdata_q;
        cont_d   = cont_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    op_del_d = ~bus.add_anchor;
                    cl_d     = bus.anchor_level;
                    ci_d     = idx_masked;
                    cont_d   = 1'b0;
                    err_d    = ~lvl_valid;
                    state_d  = lvl_valid ? ST_RD : ST_DONE;
                end
            end
            ST_RD: state_d = ST_CHECK;
            ST_CHECK: begin
                // Early exit when the slot already holds the wanted value.
                if (!op_del_q) begin
                    if ((bus.mem_rdata & slot_bit) != '0) begin
                        state_d = ST_DONE;
                    end else begin
                        wdata_d = mask_set;
                        cont_d  = (bus.mem_rdata == '0) && (plvl != '0);
                        state_d = ST_WR;
                    end
                end else begin
                    if ((bus.mem_rdata & slot_bit) == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        wdata_d = mask_clr;
                        cont_d  = PRUNE && (mask_clr == '0) && (plvl != '0);
                        state_d = ST_WR;
                    end
                end
            end
            ST_WR: begin
                if (cont_q) begin
                    cl_d    = plvl;
                    ci_d    = ci_q >> 3;
                    state_d = ST_RD;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_del_q <= 1'b0;
            err_q    <= 1'b0;
            cl_q     <= '0;
            ci_q     <= '0;
            wdata_q  <= '0;
            cont_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_del_q <= op_del_d;
            err_q    <= err_d;
            cl_q     <= cl_d;
            ci_q     <= ci_d;
            wdata_q  <= wdata_d;
            cont_q   <= cont_d;
        end
    end

    // Every output is a pure decode of state, so reset forces all of them to 0.
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.add_done  = (state_q == ST_DONE) && !op_del_q;
    assign bus.del_done  = (state_q == ST_DONE) && op_del_q;
    assign bus.err       = (state_q == ST_DONE) && err_q;
    assign bus.mem_req   = (state_q == ST_RD) || (state_q == ST_WR);
    assign bus.mem_we    = (state_q == ST_WR);
    assign bus.mem_addr  = bus.mem_req ? paddr : '0;
    assign bus.mem_wdata = (state_q == ST_WR) ? wdata_q : '0;
endmodule

// File: tb/tb_octree_updater.sv
// Randomized self-checking bench for octree_updater against a walk-level reference model
// that keeps its own copy of the node SRAM.
module tb_octree_updater;
    localparam int TREE_DEPTH = 4;
    localparam int LVL_W      = 2;
    localparam int IDX_W      = 9;
    localparam int ADDR_W     = 12;
    localparam int NODES      = ((1 << (3 * TREE_DEPTH)) - 1) / 7;

`ifdef OCTREE_DEL_PRUNE_EN
    localparam bit PRUNE = 1'b1;
`else
    localparam bit PRUNE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    octree_updater_if #(.LVL_W(LVL_W), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) bus ();

    octree_updater #(
        .TREE_DEPTH(TREE_DEPTH), .LVL_W(LVL_W), .IDX_W(IDX_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] sram    [0:(1<<ADDR_W)-1];
    logic [7:0] ref_mem [0:(1<<ADDR_W)-1];
    int n_vec = 0;
    int n_bad = 0;
    int wq_addr[$];
    int wq_data[$];
    int ex_addr[$];
    int ex_data[$];
    int rd_cnt  = 0;
    int add_cnt = 0;
    int del_cnt = 0;

    // Node SRAM with one-cycle registered read.
    always @(posedge clk) begin
        if (bus.mem_req) begin
            if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= sram[bus.mem_addr];
        end
    end

    always @(negedge clk) begin
        if (bus.mem_req && bus.mem_we) begin
            wq_addr.push_back(int'(bus.mem_addr));
            wq_data.push_back(int'(bus.mem_wdata));
        end
        if (bus.mem_req && !bus.mem_we) rd_cnt++;
        if (bus.add_done) add_cnt++;
        if (bus.del_done) del_cnt++;
    end

    // Reference: walk the tree on ref_mem, producing expected writes, reads and done cycle.
    task automatic ref_walk(input bit is_del, input int level, input int idx,
                            output int cyc, output bit e, output int rd);
        int cl, ci, pl, pi, a, k;
        logic [7:0] m, b, nm;
        bit fin;
        ex_addr.delete();
        ex_data.delete();
        e = 1'b0; rd = 0; cyc = 0;
        if (level == 0 || level >= TREE_DEPTH) begin
            e = 1'b1; cyc = 1;
            return;
        end
        cl = level; ci = idx & ((1 << (3 * level)) - 1); k = 0; fin = 1'b0;
        while (!fin) begin
            pl = cl - 1;
            pi = ci >> 3;
            a  = (8 ** pl - 1) / 7 + pi;
            b  = 8'(1 << (ci % 8));
            m  = ref_mem[a];
            rd++;
            if ((!is_del && (m & b) != 0) || (is_del && (m & b) == 0)) begin
                cyc = 3 * k + 3; fin = 1'b1;
            end else begin
                nm = is_del ? (m & ~b) : (m | b);
                ref_mem[a] = nm;
                ex_addr.push_back(a);
                ex_data.push_back(int'(nm));
                k++;
                if (pl > 0 && (is_del ? (PRUNE && nm == 0) : (m == 0))) begin
                    cl = pl; ci = pi;
                end else begin
                    cyc = 3 * k + 1; fin = 1'b1;
                end
            end
        end
    endtask

    // Caller must be just past a rising edge with the DUT idle; returns the same way.
    task automatic do_op(input bit add, input bit del, input int level, input int idx,
                         input bit intrude, input string tag);
        int exp_cyc, exp_rd, rd0, a0, d0, n, got_cyc;
        bit exp_err, is_del, got, err_seen, done_del;
        is_del = !add;
        ref_walk(is_del, level, idx, exp_cyc, exp_err, exp_rd);
        wq_addr.delete(); wq_data.delete();
        rd0 = rd_cnt; a0 = add_cnt; d0 = del_cnt;
        bus.add_anchor   = add;
        bus.del_anchor   = del;
        bus.anchor_level = LVL_W'(level);
        bus.anchor_idx   = IDX_W'(idx);
        @(posedge clk); #1;
        bus.add_anchor = 1'b0;
        bus.del_anchor = 1'b0;
        got = 1'b0; n = 0; got_cyc = 0; err_seen = 1'b0; done_del = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                n_vec++;
                if (bus.busy !== 1'b1) begin
                    n_bad++; $display("FAIL %s busy: got %b want 1", tag, bus.busy);
                end
            end
            if (intrude && !exp_err && n == 1) begin
                bus.add_anchor   = 1'b1;
                bus.del_anchor   = 1'($urandom_range(0, 1));
                bus.anchor_level = LVL_W'($urandom_range(1, 3));
                bus.anchor_idx   = IDX_W'($urandom_range(0, 511));
            end
            if (n == 2) begin
                bus.add_anchor = 1'b0;
                bus.del_anchor = 1'b0;
            end
            if (bus.add_done || bus.del_done) begin
                got = 1'b1; got_cyc = n; err_seen = bus.err; done_del = bus.del_done;
            end
        end
        bus.add_anchor = 1'b0;
        bus.del_anchor = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (!got) begin
            n_bad++; $display("FAIL %s timeout: no done within %0d cycles, want cycle %0d", tag, n, exp_cyc);
        end else if (got_cyc != exp_cyc) begin
            n_bad++; $display("FAIL %s done_cycle: got %0d want %0d", tag, got_cyc, exp_cyc);
        end
        n_vec++;
        if (got && done_del !== is_del) begin
            n_bad++; $display("FAIL %s done_kind: got del=%b want del=%b", tag, done_del, is_del);
        end
        n_vec++;
        if (got && err_seen !== exp_err) begin
            n_bad++; $display("FAIL %s err: got %b want %b", tag, err_seen, exp_err);
        end
        n_vec++;
        if ((add_cnt - a0) != (is_del ? 0 : 1) || (del_cnt - d0) != (is_del ? 1 : 0)) begin
            n_bad++; $display("FAIL %s done_pulses: got add=%0d del=%0d want add=%0d del=%0d",
                              tag, add_cnt - a0, del_cnt - d0, is_del ? 0 : 1, is_del ? 1 : 0);
        end
        n_vec++;
        if ((rd_cnt - rd0) != exp_rd) begin
            n_bad++; $display("FAIL %s reads: got %0d want %0d", tag, rd_cnt - rd0, exp_rd);
        end
        n_vec++;
        if (wq_addr.size() != ex_addr.size()) begin
            n_bad++; $display("FAIL %s write_count: got %0d want %0d", tag, wq_addr.size(), ex_addr.size());
        end else begin
            for (int i = 0; i < ex_addr.size(); i++) begin
                n_vec++;
                if (wq_addr[i] != ex_addr[i] || wq_data[i] != ex_data[i]) begin
                    n_bad++; $display("FAIL %s write%0d: got addr %0d data %02h want addr %0d data %02h",
                                      tag, i, wq_addr[i], wq_data[i], ex_addr[i], ex_data[i]);
                end
            end
        end
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL %s idle_after: busy got %b want 0", tag, bus.busy);
        end
        $display("op %s add=%b del=%b lvl=%0d idx=%0d done_cycle=%0d err=%b writes=%0d",
                 tag, add, del, level, idx, got_cyc, err_seen, wq_addr.size());
    endtask

    task automatic test_reset();
        bus.add_anchor = 1'b0; bus.del_anchor = 1'b0;
        bus.anchor_level = '0; bus.anchor_idx = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.busy, bus.add_done, bus.del_done, bus.err, bus.mem_req, bus.mem_we,
             bus.mem_addr, bus.mem_wdata} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: busy=%b done=%b%b err=%b req=%b we=%b addr=%0d wdata=%02h want all 0",
                              bus.busy, bus.add_done, bus.del_done, bus.err, bus.mem_req, bus.mem_we,
                              bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_directed();
        do_op(1'b1, 1'b0, 3, 83, 1'b0, "insert");
        do_op(1'b1, 1'b0, 3, 84, 1'b0, "sibling_insert");
        do_op(1'b1, 1'b0, 3, 84, 1'b0, "repeat_insert");
        do_op(1'b0, 1'b1, 3, 84, 1'b0, "delete_sibling");
        do_op(1'b0, 1'b1, 3, 83, 1'b0, "delete_prune");
        do_op(1'b1, 1'b0, 0, 5, 1'b0, "invalid_level");
    endtask

    task automatic test_collision();
        do_op(1'b1, 1'b1, 3, 200, 1'b0, "add_del_collision");
        do_op(1'b1, 1'b0, 2, 40, 1'b1, "ignore_while_busy");
    endtask

    task automatic test_reset_mid();
        int a0, d0;
        a0 = add_cnt; d0 = del_cnt;
        wq_addr.delete(); wq_data.delete();
        bus.add_anchor = 1'b1; bus.anchor_level = LVL_W'(3); bus.anchor_idx = IDX_W'(300);
        @(posedge clk); #1;
        bus.add_anchor = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({bus.busy, bus.add_done, bus.del_done, bus.err, bus.mem_req, bus.mem_we,
             bus.mem_addr, bus.mem_wdata} !== '0) begin
            n_bad++; $display("FAIL reset_mid_outputs: busy=%b req=%b we=%b addr=%0d wdata=%02h want all 0",
                              bus.busy, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_vec++;
        if ((add_cnt - a0) != 0 || (del_cnt - d0) != 0 || wq_addr.size() != 0) begin
            n_bad++; $display("FAIL reset_mid_aftermath: done pulses %0d writes %0d want 0 and 0",
                              (add_cnt - a0) + (del_cnt - d0), wq_addr.size());
        end
        $display("reset in CHECK applied");
    endtask

    task automatic test_random();
        int level, idx;
        bit add, del, intr;
        for (int i = 0; i < 80; i++) begin
            level = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            idx   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 31);
            add   = 1'($urandom_range(0, 1));
            del   = add ? ($urandom_range(0, 7) == 0) : 1'b1;
            intr  = ($urandom_range(0, 3) == 0);
            do_op(add, del, level, idx, intr, "random");
        end
    endtask

    task automatic test_sram_image();
        for (int a = 0; a < NODES; a++) begin
            n_vec++;
            if (sram[a] !== ref_mem[a]) begin
                n_bad++; $display("FAIL sram_image addr %0d: got %02h want %02h", a, sram[a], ref_mem[a]);
            end
        end
        $display("sram image compared over %0d nodes", NODES);
    endtask

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            sram[a]    = 8'h00;
            ref_mem[a] = 8'h00;
        end
        bus.mem_rdata = 8'h00;
        test_reset();
        test_directed();
        test_collision();
        test_reset_mid();
        test_random();
        test_sram_image();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
